// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter
//   Shares the single L2 cache port between the L1 icache and L1 dcache.
//   One line transaction is in flight at a time; the granted request is
//   latched in IDLE and replayed to L2 from those registers until l2_resp.
//   The response is steered back to the owning L1 in the same cycle.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin on simultaneous requests (last_grant register,
//                dcache wins the first tie after reset)
//   undefined -> fixed priority, dcache always wins a tie
//
// Handshake: x_read/x_write are levels held by the L1 until the one-cycle
//   x_resp pulse; the L1 drops its request in the DONE cycle that follows.
//   l2_read/l2_write are held (from latched state) until one-cycle l2_resp.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_read, i_address           icache line-fill request
//   i_rdata, i_resp             icache response
//   d_read, d_write, d_address, d_wdata   dcache fill / writeback request
//   d_rdata, d_resp             dcache response
//   l2_read, l2_write, l2_address, l2_wdata   request to L2
//   l2_rdata, l2_resp           L2 response
//   dbg_state                   current FSM state (IDLE=0 SERVE_I=1 SERVE_D=2 DONE=3)

module l1_l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;
  logic              d_req;
  logic              grant_i, grant_d;
  logic              serving;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic GRANT_I = 1'b0;
  logic last_grant;
`endif

  assign d_req     = d_read | d_write;
  assign dbg_state = state;

  // Next state and grant decision
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_read) begin
          // The side that did not win last time takes the tie
          if (last_grant == GRANT_I) grant_d = 1'b1;
          else                       grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end
`else
        if (d_req)       grant_d = 1'b1;
        else if (i_read) grant_i = 1'b1;
`endif
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      SERVE_I: if (l2_resp) state_next = DONE;
      SERVE_D: if (l2_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: L2 side comes only from latched registers; rst drops the
  // request in the same cycle rather than waiting for the state to clear.
  always_comb begin
    serving    = ((state == SERVE_I) || (state == SERVE_D)) && !rst;
    l2_read    = serving && !lat_write;
    l2_write   = serving && lat_write;
    l2_address = lat_addr;
    l2_wdata   = lat_wdata;
    i_resp     = !rst && (state == SERVE_I) && l2_resp;
    d_resp     = !rst && (state == SERVE_D) && l2_resp;
    i_rdata    = l2_rdata;
    d_rdata    = l2_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        // write wins when d_read and d_write are both high
        lat_addr  <= d_address;
        lat_wdata <= d_wdata;
        lat_write <= d_write;
      end else if (grant_i) begin
        lat_addr  <= i_address;
        lat_wdata <= '0;
        lat_write <= 1'b0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)          last_grant <= GRANT_I;
    else if (grant_d) last_grant <= ~GRANT_I;
    else if (grant_i) last_grant <= GRANT_I;
  end
`endif

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("l1_l2_arbiter: d_read and d_write both high, read ignored");

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter. Inputs change on the falling edge;
// outputs are sampled on the falling edge (or #1 after a falling-edge
// change for the combinational response path).

module tb_l1_l2_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam logic [1:0] S_IDLE = 2'd0, S_SI = 2'd1, S_SD = 2'd2, S_DONE = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, l2_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, l2_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
  logic              i_resp, d_resp, l2_read, l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [LINE_W-1:0] LINE_AA = {16{8'hAA}};
  localparam logic [LINE_W-1:0] LINE_55 = {16{8'h55}};

  l1_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    checks++; if (l2_read !== 1'b0 || l2_write !== 1'b0) begin errors++; $display("FAIL reset_l2_req got rd=%b wr=%b exp 0 0", l2_read, l2_write); end
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got i=%b d=%b exp 0 0", i_resp, d_resp); end
    checks++; if (l2_address !== 16'h0 || l2_wdata !== '0) begin errors++; $display("FAIL reset_latched got addr=%h wdata=%h exp 0", l2_address, l2_wdata); end
  endtask

  task automatic test_icache_read();
    i_read = 1'b1; i_address = 16'h1230;
    @(negedge clk);
    checks++; if (dbg_state !== S_SI) begin errors++; $display("FAIL t1_state got %0d exp %0d", dbg_state, S_SI); end
    checks++; if (l2_read !== 1'b1 || l2_write !== 1'b0) begin errors++; $display("FAIL t1_l2_read got rd=%b wr=%b exp 1 0", l2_read, l2_write); end
    checks++; if (l2_address !== 16'h1230) begin errors++; $display("FAIL t1_l2_addr got %h exp 1230", l2_address); end
    @(negedge clk);
    checks++; if (i_resp !== 1'b0 || l2_read !== 1'b1) begin errors++; $display("FAIL t1_wait got i_resp=%b l2_read=%b exp 0 1", i_resp, l2_read); end
    @(negedge clk);
    l2_resp = 1'b1; l2_rdata = LINE_AA;
    #1;
    checks++; if (i_resp !== 1'b1 || i_rdata !== LINE_AA) begin errors++; $display("FAIL t1_i_resp got resp=%b data=%h exp 1 %h", i_resp, i_rdata, LINE_AA); end
    checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL t1_d_resp got %b exp 0", d_resp); end
    @(negedge clk);
    l2_resp = 1'b0; i_read = 1'b0;
    #1;
    checks++; if (dbg_state !== S_DONE || l2_read !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL t1_done got st=%0d rd=%b resp=%b exp 3 0 0", dbg_state, l2_read, i_resp); end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL t1_idle got %0d exp 0", dbg_state); end
  endtask

  task automatic test_dcache_write();
    int resp_cnt = 0;
    d_write = 1'b1; d_address = 16'h4000; d_wdata = LINE_55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) l2_resp = 1'b1;
      #1;
      resp_cnt += int'(d_resp);
      checks++; if (dbg_state !== S_SD || l2_write !== 1'b1 || l2_read !== 1'b0) begin errors++; $display("FAIL t2_write_c%0d got st=%0d wr=%b rd=%b exp 2 1 0", k, dbg_state, l2_write, l2_read); end
      checks++; if (l2_wdata !== LINE_55 || l2_address !== 16'h4000) begin errors++; $display("FAIL t2_data_c%0d got addr=%h wdata=%h exp 4000 %h", k, l2_address, l2_wdata, LINE_55); end
      checks++; if (i_resp !== 1'b0) begin errors++; $display("FAIL t2_i_resp_c%0d got %b exp 0", k, i_resp); end
    end
    @(negedge clk);
    l2_resp = 1'b0; d_write = 1'b0;
    #1;
    resp_cnt += int'(d_resp);
    checks++; if (dbg_state !== S_DONE || l2_write !== 1'b0) begin errors++; $display("FAIL t2_done got st=%0d wr=%b exp 3 0", dbg_state, l2_write); end
    checks++; if (resp_cnt != 1) begin errors++; $display("FAIL t2_resp_count got %0d exp 1", resp_cnt); end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL t2_idle got %0d exp 0", dbg_state); end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b1; i_address = 16'h2000;
    d_read = 1'b1; d_address = 16'h3000;
    @(negedge clk);
    checks++; if (dbg_state !== S_SD || l2_address !== 16'h3000) begin errors++; $display("FAIL t3_first got st=%0d addr=%h exp 2 3000", dbg_state, l2_address); end
    l2_resp = 1'b1; l2_rdata = {16{8'h11}};
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== {16{8'h11}}) begin errors++; $display("FAIL t3_d_resp got d=%b i=%b data=%h exp 1 0 11..", d_resp, i_resp, d_rdata); end
    @(negedge clk);
    l2_resp = 1'b0; d_read = 1'b0;
    #1;
    checks++; if (dbg_state !== S_DONE || l2_read !== 1'b0) begin errors++; $display("FAIL t3_done got st=%0d rd=%b exp 3 0", dbg_state, l2_read); end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL t3_idle got %0d exp 0", dbg_state); end
    @(negedge clk);
    checks++; if (dbg_state !== S_SI || l2_address !== 16'h2000 || l2_read !== 1'b1) begin errors++; $display("FAIL t3_second got st=%0d addr=%h rd=%b exp 1 2000 1", dbg_state, l2_address, l2_read); end
    l2_resp = 1'b1; l2_rdata = {16{8'h22}};
    #1;
    checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {16{8'h22}}) begin errors++; $display("FAIL t3_i_resp got i=%b d=%b data=%h exp 1 0 22..", i_resp, d_resp, i_rdata); end
    @(negedge clk);
    l2_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
  endtask

  // Three ties in a row; the winner re-requests during its DONE cycle.
  task automatic test_back_to_back_ties();
    logic exp_d [3];
`ifdef ARB_ROUND_ROBIN_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b1; i_address = 16'h1110;
    d_read = 1'b1; d_address = 16'h2220;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== (exp_d[r] ? S_SD : S_SI) || l2_address !== (exp_d[r] ? 16'h2220 : 16'h1110)) begin
        errors++; $display("FAIL t4_grant_r%0d got st=%0d addr=%h exp_dside=%b", r, dbg_state, l2_address, exp_d[r]);
      end
      l2_resp = 1'b1; l2_rdata = LINE_W'(r + 1);
      #1;
      checks++;
      if (d_resp !== exp_d[r] || i_resp !== !exp_d[r]) begin
        errors++; $display("FAIL t4_resp_r%0d got d=%b i=%b exp d=%b i=%b", r, d_resp, i_resp, exp_d[r], !exp_d[r]);
      end
      @(negedge clk);
      l2_resp = 1'b0;
      if (r == 2) begin i_read = 1'b0; d_read = 1'b0; end
      #1;
      checks++; if (dbg_state !== S_DONE) begin errors++; $display("FAIL t4_done_r%0d got %0d exp 3", r, dbg_state); end
      @(negedge clk);
    end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL t4_idle got %0d exp 0", dbg_state); end
  endtask

  task automatic test_mid_change();
    d_read = 1'b1; d_address = 16'h4000;
    @(negedge clk);
    checks++; if (l2_address !== 16'h4000 || l2_read !== 1'b1) begin errors++; $display("FAIL t5_addr got %h rd=%b exp 4000 1", l2_address, l2_read); end
    d_address = 16'h5000; d_write = 1'b0;
    @(negedge clk);
    checks++; if (l2_address !== 16'h4000) begin errors++; $display("FAIL t5_addr_hold got %h exp 4000", l2_address); end
    l2_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1) begin errors++; $display("FAIL t5_d_resp got %b exp 1", d_resp); end
    @(negedge clk);
    d_read = 1'b0;
    // l2_resp still high in DONE: must not be forwarded
    #1;
    checks++; if (dbg_state !== S_DONE || d_resp !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL t5_done_stray got st=%0d d=%b i=%b exp 3 0 0", dbg_state, d_resp, i_resp); end
    @(negedge clk);
    // l2_resp still high in IDLE with no requests
    #1;
    checks++; if (dbg_state !== S_IDLE || d_resp !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL t5_idle_stray got st=%0d d=%b i=%b exp 0 0 0", dbg_state, d_resp, i_resp); end
    @(negedge clk);
    l2_resp = 1'b0;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL t5_idle_stay got %0d exp 0", dbg_state); end
  endtask

  task automatic test_reset_mid();
    i_read = 1'b1; i_address = 16'h1230;
    @(negedge clk);
    checks++; if (dbg_state !== S_SI || l2_read !== 1'b1) begin errors++; $display("FAIL t6_serve got st=%0d rd=%b exp 1 1", dbg_state, l2_read); end
    rst = 1'b1; l2_resp = 1'b1;
    #1;
    checks++; if (l2_read !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL t6_drop got rd=%b resp=%b exp 0 0", l2_read, i_resp); end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE || l2_read !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL t6_idle got st=%0d rd=%b resp=%b exp 0 0 0", dbg_state, l2_read, i_resp); end
    rst = 1'b0; l2_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE || l2_read !== 1'b0) begin errors++; $display("FAIL t6_after got st=%0d rd=%b exp 0 0", dbg_state, l2_read); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_tie();
    test_back_to_back_ties();
    test_mid_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
